// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, LSB first, one bit per clock.
// out = in0 - in1 (mod 2^WIDTH), o_borrow set when in0 < in1 (unsigned).
// A start/busy/done handshake frames each operation.
module serial_sub #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             o_borrow,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  r_sr;
    logic              bw;
    logic [CW-1:0]     cnt;

    logic              d;
    logic              bw_next;
    logic              last;

    // Full-subtractor cell on the current LSBs plus next-state decode
    always_comb begin
        d       = a_sr[0] ^ b_sr[0] ^ bw;
        bw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
        last    = (state == RUN) && (cnt == LAST);
        state_n = state;
        case (state)
            IDLE:    if (i_start) state_n = RUN;
            RUN:     if (last)    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register; reset dominates a coincident start
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    // Operand shifters, borrow chain, result assembly and handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            bw       <= 1'b0;
            cnt      <= '0;
            out      <= '0;
            o_borrow <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_sr   <= in0;
                        b_sr   <= in1;
                        bw     <= 1'b0;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= {d, r_sr[WIDTH-1:1]};
                    bw   <= bw_next;
                    cnt  <= cnt + CW'(1);
                    // Final bit: publish the whole difference at once so out
                    // never shows a partially shifted value
                    if (last) begin
                        out      <= {d, r_sr[WIDTH-1:1]};
                        o_borrow <= bw_next;
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=3 and WIDTH=8.
// Stimulus pushes expected {out, borrow, done cycle}; monitors pop on o_done.
module tb_serial_sub;

    typedef struct {
        int o;
        int b;
        int c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       s3_start = 1'b0;
    logic [2:0] s3_in0 = '0, s3_in1 = '0, s3_out;
    logic       s3_borrow, s3_busy, s3_done;

    logic       s8_start = 1'b0;
    logic [7:0] s8_in0 = '0, s8_in1 = '0, s8_out;
    logic       s8_borrow, s8_busy, s8_done;

    exp_t q3[$];
    exp_t q8[$];
    int   blen3 = 0;
    int   blen8 = 0;

    serial_sub #(.WIDTH(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(s3_start),
        .in0(s3_in0), .in1(s3_in1), .out(s3_out),
        .o_borrow(s3_borrow), .o_busy(s3_busy), .o_done(s3_done)
    );

    serial_sub #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(s8_start),
        .in0(s8_in0), .in1(s8_in1), .out(s8_out),
        .o_borrow(s8_borrow), .o_busy(s8_busy), .o_done(s8_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // WIDTH=3 monitor: result, latency and busy length on every done pulse
    always @(negedge clk) begin
        if (s3_done === 1'b1) begin
            if (q3.size() == 0) begin
                chk("w3 unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("w3 out", int'(s3_out), e.o);
                chk("w3 borrow", int'(s3_borrow), e.b);
                chk("w3 done cycle", cyc, e.c);
                chk("w3 busy len", blen3, 3);
                chk("w3 busy at done", int'(s3_busy), 0);
            end
            blen3 = 0;
        end else if (s3_busy === 1'b1) begin
            blen3++;
        end else begin
            blen3 = 0;
        end
    end

    // WIDTH=8 monitor
    always @(negedge clk) begin
        if (s8_done === 1'b1) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8 out", int'(s8_out), e.o);
                chk("w8 borrow", int'(s8_borrow), e.b);
                chk("w8 done cycle", cyc, e.c);
                chk("w8 busy len", blen8, 8);
            end
            blen8 = 0;
        end else if (s8_busy === 1'b1) begin
            blen8++;
        end else begin
            blen8 = 0;
        end
    end

    // Issue one WIDTH=3 op; call at a negedge with the DUT idle or in done
    task automatic go3(input int a, input int b, input int eo, input int eb);
        exp_t e;
        s3_in0 = 3'(a);
        s3_in1 = 3'(b);
        s3_start = 1'b1;
        e.o = eo; e.b = eb; e.c = cyc + 1 + 3;
        q3.push_back(e);
        @(negedge clk);
        s3_start = 1'b0;
    endtask

    task automatic go8(input int a, input int b, input int eo, input int eb);
        exp_t e;
        s8_in0 = 8'(a);
        s8_in1 = 8'(b);
        s8_start = 1'b1;
        e.o = eo; e.b = eb; e.c = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        s8_start = 1'b0;
    endtask

    task automatic drain3();
        for (int i = 0; i < 40 && q3.size() != 0; i++) @(negedge clk);
        if (q3.size() != 0) begin
            chk("w3 drain timeout", q3.size(), 0);
            q3.delete();
        end
        @(negedge clk);
    endtask

    task automatic drain8();
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            chk("w8 drain timeout", q8.size(), 0);
            q8.delete();
        end
        @(negedge clk);
    endtask

    // Wait (bounded) for the negedge inside a WIDTH=3 done cycle
    task automatic wait_done3();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (s3_done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("w3 done wait timeout", 0, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst out3", int'(s3_out), 0);
        chk("rst borrow3", int'(s3_borrow), 0);
        chk("rst busy3", int'(s3_busy), 0);
        chk("rst done3", int'(s3_done), 0);
        chk("rst out8", int'(s8_out), 0);
        chk("rst busy8", int'(s8_busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic and underflow
        go3(5, 2, 3, 0);
        drain3();
        go3(2, 7, 3, 1);
        drain3();
        go3(0, 0, 0, 0);
        drain3();

        // Adder inverse, each start issued in the previous done cycle
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                if (a != 0 || b != 0) wait_done3();
                go3((a + b) & 7, b, a, 0);
            end
        end
        drain3();

        // Start held through RUN with inputs changing mid-operation
        begin
            exp_t e;
            s3_in0 = 3'd5; s3_in1 = 3'd2; s3_start = 1'b1;
            e.o = 3; e.b = 0; e.c = cyc + 1 + 3;
            q3.push_back(e);
            @(negedge clk);
            s3_in0 = 3'd7; s3_in1 = 3'd1;
            @(negedge clk);
            s3_in0 = 3'd6; s3_in1 = 3'd4;
            e.o = 2; e.b = 0; e.c = cyc + 2 * 3;
            q3.push_back(e);
            repeat (3) @(negedge clk);
            s3_start = 1'b0;
        end
        drain3();

        // Reset on the 2nd RUN edge aborts the op without a done pulse
        s3_in0 = 3'd3; s3_in1 = 3'd1; s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort out", int'(s3_out), 0);
        chk("abort borrow", int'(s3_borrow), 0);
        chk("abort busy", int'(s3_busy), 0);
        chk("abort done", int'(s3_done), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        go3(6, 1, 5, 0);
        drain3();

        // WIDTH=8
        go8(8'h10, 8'h01, 8'h0F, 0);
        drain8();
        go8(8'h00, 8'hFF, 8'h01, 1);
        drain8();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial subtractor computing `out = in0 - in1` modulo 2^WIDTH, LSB first, one bit per clock, with a final borrow flag. It is the inverse of the registered adder datapath on the same board. It takes a registered sum on `in0` and one addend on `in1`, and recovers the other addend. A start/busy/done handshake frames each operation, so a controller can check adder results without a second parallel datapath.

## Interface
- WIDTH, 3, operand and result width in bits. Legal range 2..16.
- i_clk  in  1  system clock. All logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request an operation. Sampled only in IDLE.
- in0  in  WIDTH  minuend, for example the adder sum.
- in1  in  WIDTH  subtrahend, for example one adder operand, zero-extended.
- out  out  WIDTH  difference. Updated only at completion; holds between operations.
- o_borrow  out  1  final borrow (in0 < in1 unsigned). Updated with `out`.
- o_busy  out  1  high while an operation is in progress.
- o_done  out  1  one-cycle pulse marking that `out` and `o_borrow` are newly valid.

## Operation
- States: IDLE and RUN. A bit counter runs 0..WIDTH-1.
- **IDLE, i_start=1:**
  - Latch in0 into shift register A and in1 into shift register B.
  - Clear the internal borrow and the counter.
  - Go to RUN and set o_busy=1.
- **IDLE, i_start=0:** remain in IDLE. All outputs hold, except o_done, which is 0.
- **RUN, every cycle:**
  - d = A[0] ^ B[0] ^ bw.
  - bw_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & bw).
  - Shift A and B right by one.
  - Shift d into the MSB of the internal result register R.
  - Increment the counter.
- **RUN, counter == WIDTH-1:**
  - out <= {d, R[WIDTH-1:1]} (the complete difference).
  - o_borrow <= bw_next.
  - o_done <= 1, o_busy <= 0, go to IDLE.
- i_start is ignored in RUN. Input changes after the start sample do not affect the operation in flight.
- Arithmetic: the result is the unsigned difference modulo 2^WIDTH. o_borrow=1 exactly when in0 < in1.
- **Reset:** applies in any state, including mid-operation.
  - State goes to IDLE.
  - out=0, o_borrow=0, o_busy=0, o_done=0, and the internal registers are cleared.
  - An aborted operation produces no o_done.
- **Reset and i_start in the same cycle:** reset wins and the start is dropped.

## Timing
- Start sampled at edge k → o_busy=1 after edge k.
- The WIDTH RUN edges are k+1 .. k+WIDTH.
- After edge k+WIDTH:
  - o_done=1 and o_busy=0.
  - `out` and `o_borrow` hold the new result.
- Latency from the start-sample edge to o_done is WIDTH cycles. o_busy is high for exactly WIDTH cycles.
- o_done lasts exactly one cycle. It falls after edge k+WIDTH+1 unless a new result completes on that edge, which is impossible for WIDTH≥2.
- Back-to-back: the machine is in IDLE during the o_done cycle, so i_start=1 there is accepted. Throughput is one result per WIDTH+1 cycles.
- o_borrow and `out` never change except at a completion edge or on reset.

## Test plan
- **Basic subtraction:** WIDTH=3, reset, then in0=5, in1=2, one-cycle i_start.
  - o_busy high for 3 cycles.
  - o_done pulses 3 cycles after the start edge with out=3, o_borrow=0.
- **Underflow:** in0=2, in1=7 → out=3 (−5 mod 8), o_borrow=1. Also 0−0 → out=0, o_borrow=0.
- **Inverse of the adder:** for all a, b in 0..3, present in0=a+b (3-bit) and in1=b.
  - Every run must give out=a and o_borrow=0.
  - Issue each start in the previous o_done cycle to also check back-to-back acceptance.
- **Start while busy:** assert i_start continuously through RUN and change in0/in1 mid-operation.
  - The first result reflects only the values latched at the start edge.
  - The next operation begins only at the o_done cycle.
- **Reset mid-operation:** assert i_rst on the 2nd RUN cycle.
  - Next cycle: out=0, o_borrow=0, o_busy=0, and no o_done pulse ever follows.
  - A fresh start (6−1) then gives out=5.
- **WIDTH=8:** in0=0x10, in1=0x01 → out=0x0F, o_borrow=0, latency 8. Then in0=0x00, in1=0xFF → out=0x01, o_borrow=1.
